// File: rtl/lc3_decode_queue_if.sv
// Decode-queue bus: fetch-side push handshake, execute-side pop handshake and the
// decode_out payload. The master drives the fetch/execute stimulus; the slave is the queue.
interface lc3_decode_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NPC_W = 16
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic             enable_decode;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_IR;
    logic [NPC_W-1:0] in_npc;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      IR;
    logic [NPC_W-1:0] npc_out;
    logic [5:0]       E_control;
    logic [1:0]       W_control;
    logic             mem_control;
    logic [CntW-1:0]  count;

    modport master (
        output enable_decode, flush, in_valid, in_IR, in_npc, out_ready,
        input  in_ready, out_valid, IR, npc_out, E_control, W_control, mem_control, count
    );

    modport slave (
        input  enable_decode, flush, in_valid, in_IR, in_npc, out_ready,
        output in_ready, out_valid, IR, npc_out, E_control, W_control, mem_control, count
    );
endinterface

// File: rtl/lc3_decode_queue.sv
// LC3 decode stage with a DEPTH-entry first-word-fall-through queue. Instructions are
// decoded at push time and stored decoded, so execute back-pressure only stalls fetch
// once the queue is full. Head outputs are registered.
module lc3_decode_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NPC_W = 16
) (
    input logic              clock,
    input logic              reset,
    lc3_decode_queue_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [15:0]      ir;
        logic [NPC_W-1:0] npc;
        logic [5:0]       e_ctl;
        logic [1:0]       w_ctl;
        logic             mem_ctl;
    } entry_t;

    // Decode fields of the incoming instruction.
    logic [3:0] op;
    logic [1:0] alu_ctl;
    logic [1:0] pcsel1;
    logic       pcsel2;
    logic       op2sel;
    logic [1:0] w_ctl;
    logic       mem_ctl;
    entry_t     din;

    // Queue state.
    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [CntW-1:0]   cnt_after_pop;
    logic              out_valid_q, out_valid_d;
    entry_t            head_q, head_d;

    logic full;
    logic push;
    logic pop;

    assign op = bus.in_IR[15:12];

    // Opcode decode into execute/writeback/memory controls; unknown opcodes decode as NOP.
    always_comb begin
        alu_ctl = 2'b00;
        pcsel1  = 2'b00;
        pcsel2  = 1'b0;
        op2sel  = 1'b0;
        w_ctl   = 2'd0;
        mem_ctl = 1'b0;
        case (op)
            4'b0001: begin // ADD
                alu_ctl = 2'b00;
                op2sel  = ~bus.in_IR[5];
            end
            4'b0101: begin // AND
                alu_ctl = 2'b01;
                op2sel  = ~bus.in_IR[5];
            end
            4'b1001: begin // NOT
                alu_ctl = 2'b10;
                op2sel  = 1'b1;
            end
            4'b0000, 4'b0011: begin // BR, ST
                pcsel1 = 2'b01;
                pcsel2 = 1'b1;
            end
            4'b0010: begin // LD
                pcsel1 = 2'b01;
                pcsel2 = 1'b1;
                w_ctl  = 2'd1;
            end
            4'b1010: begin // LDI
                pcsel1  = 2'b01;
                pcsel2  = 1'b1;
                w_ctl   = 2'd1;
                mem_ctl = 1'b1;
            end
            4'b1011: begin // STI
                pcsel1  = 2'b01;
                pcsel2  = 1'b1;
                mem_ctl = 1'b1;
            end
            4'b1110: begin // LEA
                pcsel1 = 2'b01;
                pcsel2 = 1'b1;
                w_ctl  = 2'd2;
            end
            4'b0110: begin // LDR
                pcsel1 = 2'b10;
                w_ctl  = 2'd1;
            end
            4'b0111: begin // STR
                pcsel1 = 2'b10;
            end
            4'b1100: begin // JMP
                pcsel1 = 2'b11;
            end
            default: ;
        endcase
    end

    // Pack the decoded entry as it will be stored.
    always_comb begin
        din         = '0;
        din.ir      = bus.in_IR;
        din.npc     = bus.in_npc;
        din.e_ctl   = {alu_ctl, pcsel1, pcsel2, op2sel};
        din.w_ctl   = w_ctl;
        din.mem_ctl = mem_ctl;
    end

    // Handshakes: full blocks push even when popping in the same cycle (no bypass).
    assign full         = (count_q == CntW'(DEPTH));
    assign bus.in_ready = ~full & ~bus.flush & bus.enable_decode;
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = out_valid_q & bus.out_ready & bus.enable_decode & ~bus.flush;

    // Next-state for pointers, occupancy and the registered head.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        out_valid_d   = out_valid_q;
        head_d        = head_q;
        cnt_after_pop = count_q - CntW'(pop);
        if (bus.enable_decode) begin
            if (bus.flush) begin
                wr_ptr_d    = '0;
                rd_ptr_d    = '0;
                count_d     = '0;
                out_valid_d = 1'b0;
                head_d      = '0;
            end else begin
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PtrW'(1);
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PtrW'(1);
                end
                count_d     = cnt_after_pop + CntW'(push);
                out_valid_d = (count_d != '0);
                // An entry pushed into an otherwise-empty queue is not in storage yet,
                // so load the head straight from the decoder.
                if (push && cnt_after_pop == '0) begin
                    head_d = din;
                end else if (count_d != '0) begin
                    head_d = mem_q[rd_ptr_d];
                end
                // Empty after this cycle: the head keeps the last popped value.
            end
        end
    end

    // Storage write for accepted pushes.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
        end
    end

    // Queue storage; contents are only read once written, so no reset is needed.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Control and head registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            head_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.IR          = head_q.ir;
    assign bus.npc_out     = head_q.npc;
    assign bus.E_control   = head_q.e_ctl;
    assign bus.W_control   = head_q.w_ctl;
    assign bus.mem_control = head_q.mem_ctl;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_lc3_decode_queue.sv
// Self-checking bench for lc3_decode_queue: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_lc3_decode_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NPC_W = 16;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    typedef struct {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    exp_t mq[$];
    exp_t mhead;
    logic mvalid = 1'b0;

    always #5 clock = ~clock;

    lc3_decode_queue_if #(.DEPTH(DEPTH), .NPC_W(NPC_W)) bus ();

    lc3_decode_queue #(.DEPTH(DEPTH), .NPC_W(NPC_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference decode, from the opcode classes of the instruction set.
    function automatic exp_t ref_decode(input logic [15:0] ir, input logic [15:0] npc);
        exp_t r;
        int   op;
        op = int'(ir[15:12]);
        r.ir = ir; r.npc = npc; r.e = 6'd0; r.w = 2'd0; r.m = 1'b0;
        if (op == 1) begin r.e[5:4] = 2'd0; r.e[0] = !ir[5]; end
        if (op == 5) begin r.e[5:4] = 2'd1; r.e[0] = !ir[5]; end
        if (op == 9) begin r.e[5:4] = 2'd2; r.e[0] = 1'b1; end
        if (op inside {0, 2, 10, 3, 11, 14}) begin r.e[3:2] = 2'd1; r.e[1] = 1'b1; end
        if (op inside {6, 7}) r.e[3:2] = 2'd2;
        if (op == 12) r.e[3:2] = 2'd3;
        if (op inside {2, 6, 10}) r.w = 2'd1;
        if (op == 14) r.w = 2'd2;
        r.m = (op == 10 || op == 11);
        return r;
    endfunction

    function automatic logic model_ready();
        return bus.enable_decode && !bus.flush && (mq.size() < DEPTH);
    endfunction

    function automatic exp_t zero_entry();
        exp_t z;
        z.ir = '0; z.npc = '0; z.e = '0; z.w = '0; z.m = 1'b0;
        return z;
    endfunction

    // Reference model advances on every clock edge from the inputs the bench is driving.
    always @(posedge clock) begin
        logic rdy;
        if (reset) begin
            mq.delete();
            mhead  = zero_entry();
            mvalid = 1'b0;
        end else if (bus.enable_decode) begin
            if (bus.flush) begin
                mq.delete();
                mhead = zero_entry();
            end else begin
                rdy = model_ready();
                if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
                if (bus.in_valid && rdy) mq.push_back(ref_decode(bus.in_IR, bus.in_npc));
                if (mq.size() > 0) mhead = mq[0];
            end
            mvalid = (mq.size() > 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.enable_decode = 1'b1;
        bus.flush         = 1'b0;
        bus.in_valid      = 1'b0;
        bus.out_ready     = 1'b0;
        bus.in_IR         = '0;
        bus.in_npc        = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.in_valid = 1'b1;
        bus.in_IR    = 16'h1261;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        tick(2);
        checks++; if (bus.out_valid !== 1'b0) begin failures++;
            $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.count !== CntW'(0)) begin failures++;
            $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.E_control !== 6'd0 || bus.W_control !== 2'd0) begin failures++;
            $display("FAIL reset_ctl got=%b/%0d exp=0/0", bus.E_control, bus.W_control); end
        checks++; if (bus.IR !== 16'h0 || bus.npc_out !== 16'h0 || bus.mem_control !== 1'b0)
            begin failures++;
            $display("FAIL reset_data got=%h/%h/%b exp=0", bus.IR, bus.npc_out,
                     bus.mem_control); end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_push();
        apply_reset();
        bus.in_valid = 1'b1; bus.in_IR = 16'h1261; bus.in_npc = 16'h3001;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++;
            $display("FAIL empty_ready got=%b exp=1", bus.in_ready); end
        tick(1);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.count !== CntW'(1)) begin failures++;
            $display("FAIL push_latency got=%b/%0d exp=1/1", bus.out_valid, bus.count); end
        checks++; if (bus.IR !== 16'h1261 || bus.npc_out !== 16'h3001) begin failures++;
            $display("FAIL add_data got=%h/%h exp=1261/3001", bus.IR, bus.npc_out); end
        checks++; if (bus.E_control !== 6'b000000 || bus.W_control !== 2'd0 ||
                      bus.mem_control !== 1'b0) begin failures++;
            $display("FAIL add_ctl got=%b/%0d/%b exp=000000/0/0", bus.E_control,
                     bus.W_control, bus.mem_control); end
    endtask

    task automatic test_decode_pair();
        apply_reset();
        bus.in_valid = 1'b1; bus.in_IR = 16'h5042; bus.in_npc = 16'h0100;
        tick(1);
        bus.in_IR = 16'hA605; bus.in_npc = 16'h0101;
        tick(1);
        bus.in_valid = 1'b0;
        checks++; if (bus.E_control !== 6'b010001 || bus.W_control !== 2'd0 ||
                      bus.count !== CntW'(2)) begin failures++;
            $display("FAIL and_ctl got=%b/%0d/%0d exp=010001/0/2", bus.E_control,
                     bus.W_control, bus.count); end
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        checks++; if (bus.IR !== 16'hA605 || bus.E_control !== 6'b000110 ||
                      bus.W_control !== 2'd1 || bus.mem_control !== 1'b1) begin failures++;
            $display("FAIL ldi_ctl got=%h/%b/%0d/%b exp=a605/000110/1/1", bus.IR,
                     bus.E_control, bus.W_control, bus.mem_control); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [5];
        vals = '{16'h1021, 16'h5262, 16'h9FFF, 16'h6443, 16'hC1C0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_IR = vals[i]; bus.in_npc = 16'(16'h4000 + i);
            #1;
            checks++; if (bus.in_ready !== (i < 4)) begin failures++;
                $display("FAIL fill_ready_%0d got=%b exp=%b", i, bus.in_ready, i < 4); end
            tick(1);
        end
        checks++; if (bus.count !== CntW'(4) || bus.in_ready !== 1'b0) begin failures++;
            $display("FAIL full_state got=%0d/%b exp=4/0", bus.count, bus.in_ready); end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++;
            $display("FAIL full_pop_ready got=%b exp=0", bus.in_ready); end
        tick(1);
        bus.out_ready = 1'b0;
        checks++; if (bus.count !== CntW'(3) || bus.in_ready !== 1'b1) begin failures++;
            $display("FAIL after_pop got=%0d/%b exp=3/1", bus.count, bus.in_ready); end
        tick(1);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.IR !== vals[k] ||
                          bus.npc_out !== 16'(16'h4000 + k)) begin failures++;
                $display("FAIL order_%0d got=%b/%h/%h exp=1/%h/%h", k, bus.out_valid,
                         bus.IR, bus.npc_out, vals[k], 16'(16'h4000 + k)); end
            tick(1);
        end
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.count !== CntW'(0) ||
                      bus.IR !== vals[4]) begin failures++;
            $display("FAIL drained got=%b/%0d/%h exp=0/0/%h", bus.out_valid, bus.count,
                     bus.IR, vals[4]); end
    endtask

    task automatic test_flush();
        apply_reset();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_IR = 16'(16'h2200 + i); bus.in_npc = 16'(16'h0050 + i);
            tick(1);
        end
        checks++; if (bus.count !== CntW'(3)) begin failures++;
            $display("FAIL pre_flush_count got=%0d exp=3", bus.count); end
        bus.in_IR = 16'h1234; bus.out_ready = 1'b1; bus.flush = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++;
            $display("FAIL flush_ready got=%b exp=0", bus.in_ready); end
        tick(1);
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        checks++; if (bus.count !== CntW'(0) || bus.out_valid !== 1'b0) begin failures++;
            $display("FAIL flush_state got=%0d/%b exp=0/0", bus.count, bus.out_valid); end
        checks++; if (bus.IR !== 16'h0 || bus.npc_out !== 16'h0 || bus.E_control !== 6'd0)
            begin failures++;
            $display("FAIL flush_zero got=%h/%h/%b exp=0", bus.IR, bus.npc_out,
                     bus.E_control); end
        bus.in_valid = 1'b1; bus.in_IR = 16'h6042; bus.in_npc = 16'h0777;
        tick(1);
        bus.in_valid = 1'b0;
        checks++; if (bus.IR !== 16'h6042 || bus.E_control !== 6'b001000 ||
                      bus.W_control !== 2'd1 || bus.count !== CntW'(1)) begin failures++;
            $display("FAIL post_flush got=%h/%b/%0d/%0d exp=6042/001000/1/1", bus.IR,
                     bus.E_control, bus.W_control, bus.count); end
    endtask

    task automatic test_enable();
        apply_reset();
        bus.in_valid = 1'b1; bus.in_IR = 16'h2001; bus.in_npc = 16'h0010;
        tick(1);
        bus.in_IR = 16'h3002; bus.in_npc = 16'h0011;
        tick(1);
        bus.in_IR = 16'h7777; bus.out_ready = 1'b1; bus.enable_decode = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++;
            $display("FAIL disabled_ready got=%b exp=0", bus.in_ready); end
        for (int c = 0; c < 3; c++) begin
            bus.flush = (c == 1);
            tick(1);
            checks++; if (bus.count !== CntW'(2) || bus.IR !== 16'h2001 ||
                          bus.npc_out !== 16'h0010) begin failures++;
                $display("FAIL hold_%0d got=%0d/%h/%h exp=2/2001/0010", c, bus.count,
                         bus.IR, bus.npc_out); end
        end
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.enable_decode = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        checks++; if (bus.count !== CntW'(1) || bus.IR !== 16'h3002) begin failures++;
            $display("FAIL reenable_pop got=%0d/%h exp=1/3002", bus.count, bus.IR); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            bus.enable_decode = ($urandom_range(0, 9) != 0);
            bus.flush         = ($urandom_range(0, 19) == 0);
            bus.in_valid      = ($urandom_range(0, 9) < 6);
            bus.out_ready     = ($urandom_range(0, 9) < 5);
            bus.in_IR         = 16'($urandom);
            bus.in_npc        = 16'($urandom);
            reset             = ($urandom_range(0, 99) == 0);
            #1;
            checks++; if (bus.in_ready !== model_ready()) begin failures++;
                $display("FAIL rnd_ready_%0d got=%b exp=%b", c, bus.in_ready,
                         model_ready()); end
            tick(1);
            checks++; if (bus.out_valid !== mvalid || bus.count !== CntW'(mq.size()))
                begin failures++;
                $display("FAIL rnd_occ_%0d got=%b/%0d exp=%b/%0d", c, bus.out_valid,
                         bus.count, mvalid, mq.size()); end
            checks++; if (bus.IR !== mhead.ir || bus.npc_out !== mhead.npc ||
                          bus.E_control !== mhead.e || bus.W_control !== mhead.w ||
                          bus.mem_control !== mhead.m) begin failures++;
                $display("FAIL rnd_head_%0d got=%h/%h/%b/%0d/%b exp=%h/%h/%b/%0d/%b", c,
                         bus.IR, bus.npc_out, bus.E_control, bus.W_control,
                         bus.mem_control, mhead.ir, mhead.npc, mhead.e, mhead.w, mhead.m);
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        mhead = zero_entry();
        test_reset();
        test_single_push();
        test_decode_pair();
        test_back_to_back();
        test_flush();
        test_enable();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
